// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arb_pkg;

  localparam int unsigned N_REQ  = 2;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 5;
  localparam int unsigned FLAG_W = 3;
  localparam int unsigned CNT_W  = 4;

  // rsp_flags bit positions
  localparam int unsigned FLAG_NE  = 2;
  localparam int unsigned FLAG_LT  = 1;
  localparam int unsigned FLAG_OVF = 0;

  // ALU opcodes (passed through unchecked by the arbiter)
  localparam logic [OP_W-1:0] OP_ADD = 5'b00000;
  localparam logic [OP_W-1:0] OP_SUB = 5'b00001;
  localparam logic [OP_W-1:0] OP_AND = 5'b00010;
  localparam logic [OP_W-1:0] OP_OR  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SLL = 5'b00100;
  localparam logic [OP_W-1:0] OP_SRA = 5'b00101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // One operation as presented to the shared ALU
  typedef struct packed {
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic [OP_W-1:0]   opcode;
    logic [OP_W-1:0]   shiftamt;
  } alu_req_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side request/response bundle for alu_arbiter.
interface alu_arbiter_if;
  import alu_arb_pkg::*;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*DATA_W-1:0] req_operandA;
  logic [N_REQ*DATA_W-1:0] req_operandB;
  logic [N_REQ*OP_W-1:0]   req_opcode;
  logic [N_REQ*OP_W-1:0]   req_shiftamt;
  logic [N_REQ-1:0]        rsp_valid;
  logic [N_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]       rsp_result;
  logic [FLAG_W-1:0]       rsp_flags;

  modport master (
    output req_valid, req_operandA, req_operandB, req_opcode, req_shiftamt, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags
  );

  modport slave (
    input  req_valid, req_operandA, req_operandB, req_opcode, req_shiftamt, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags
  );

endinterface

// File: rtl/arb2_select.sv
// Two-way arbiter: one-hot grant; pointer names the requester that wins a tie.
module arb2_select (
  input  logic [1:0] valid,
  input  logic       pointer,
  output logic [1:0] grant
);

  // Single requester wins outright; on a tie the pointer decides.
  always_comb begin
    grant = 2'b00;
    if (valid == 2'b11) begin
      grant = pointer ? 2'b10 : 2'b01;
    end else begin
      grant = valid;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters: IDLE -> EXEC -> RESP.
// Optional feature: define ALU_ARB_RR_EN for round-robin arbitration,
// otherwise requester 0 has fixed priority.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_arbiter_if.slave      bus,
  output logic [DATA_W-1:0] alu_operandA,
  output logic [DATA_W-1:0] alu_operandB,
  output logic [OP_W-1:0]   alu_opcode,
  output logic [OP_W-1:0]   alu_shiftamt,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_isNotEqual,
  input  logic              alu_isLessThan,
  input  logic              alu_overflow,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

  state_t             state;
  logic               accept_en;
  logic               gnt_idx;
  logic [CNT_W-1:0]   cnt;
  logic               settle;
  alu_req_t           op_q;
  alu_req_t           op_sel;
  logic [N_REQ-1:0]   sel;
  logic               ptr;
  logic               hs;
  logic [N_REQ-1:0]   rsp_valid_q;
  logic [DATA_W-1:0]  rsp_result_q;
  logic [FLAG_W-1:0]  rsp_flags_q;
  logic               busy_q;

  arb2_select u_arb (
    .valid   (bus.req_valid),
    .pointer (ptr),
    .grant   (sel)
  );

`ifdef ALU_ARB_RR_EN
  logic rr_ptr;

  // Round-robin pointer: the requester not granted last has priority next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (hs) begin
      rr_ptr <= ~sel[1];
    end
  end

  assign ptr = rr_ptr;
`else
  assign ptr = 1'b0;
`endif

  // accept_en is low in reset and everywhere outside IDLE, so ready never leaks.
  assign bus.req_ready = accept_en ? sel : '0;
  assign hs            = |(bus.req_valid & bus.req_ready);

  // Pick the granted requester's packed fields.
  always_comb begin
    op_sel           = '0;
    op_sel.operand_a = sel[1] ? bus.req_operandA[2*DATA_W-1:DATA_W] : bus.req_operandA[DATA_W-1:0];
    op_sel.operand_b = sel[1] ? bus.req_operandB[2*DATA_W-1:DATA_W] : bus.req_operandB[DATA_W-1:0];
    op_sel.opcode    = sel[1] ? bus.req_opcode[2*OP_W-1:OP_W]       : bus.req_opcode[OP_W-1:0];
    op_sel.shiftamt  = sel[1] ? bus.req_shiftamt[2*OP_W-1:OP_W]     : bus.req_shiftamt[OP_W-1:0];
  end

  // Main FSM. The first EXEC cycle lets the ALU see the freshly registered
  // operands; the counter then holds them for EXEC_CYCLES before capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      accept_en    <= 1'b0;
      gnt_idx      <= 1'b0;
      cnt          <= '0;
      settle       <= 1'b0;
      op_q         <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          accept_en <= 1'b1;
          if (hs) begin
            op_q      <= op_sel;
            gnt_idx   <= sel[1];
            cnt       <= CNT_LOAD;
            settle    <= 1'b1;
            accept_en <= 1'b0;
            busy_q    <= 1'b1;
            state     <= EXEC;
          end
        end
        EXEC: begin
          if (settle) begin
            settle <= 1'b0;
          end else if (cnt == '0) begin
            rsp_result_q           <= alu_result;
            rsp_flags_q[FLAG_NE]   <= alu_isNotEqual;
            rsp_flags_q[FLAG_LT]   <= alu_isLessThan;
            rsp_flags_q[FLAG_OVF]  <= alu_overflow;
            rsp_valid_q            <= gnt_idx ? 2'b10 : 2'b01;
            state                  <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready[gnt_idx]) begin
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
            accept_en   <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign alu_operandA   = op_q.operand_a;
  assign alu_operandB   = op_q.operand_b;
  assign alu_opcode     = op_q.opcode;
  assign alu_shiftamt   = op_q.shiftamt;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance with EXEC_CYCLES=1, one with 4.
`timescale 1ns/1ps
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter_if bus1();
  alu_arbiter_if bus4();

  logic [31:0] a1, b1, r1, a4, b4, r4;
  logic [4:0]  op1, sh1, op4, sh4;
  logic        ne1, lt1, ov1, ne4, lt4, ov4;
  logic        busy1, busy4;

  // Stand-in for the shared ALU; unsigned less-than, signed overflow.
  function automatic logic [34:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] op, input logic [4:0] sh);
    logic [31:0] r;
    logic        ov;
    r  = 32'd0;
    ov = 1'b0;
    case (op)
      OP_ADD: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
      OP_SUB: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_SLL: r = a << sh;
      OP_SRA: r = 32'($signed(a) >>> sh);
      default: r = 32'd0;
    endcase
    return {a != b, a < b, ov, r};
  endfunction

  assign {ne1, lt1, ov1, r1} = alu_model(a1, b1, op1, sh1);
  assign {ne4, lt4, ov4, r4} = alu_model(a4, b4, op4, sh4);

  alu_arbiter #(.EXEC_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .alu_operandA(a1), .alu_operandB(b1), .alu_opcode(op1), .alu_shiftamt(sh1),
    .alu_result(r1), .alu_isNotEqual(ne1), .alu_isLessThan(lt1), .alu_overflow(ov1),
    .busy(busy1)
  );

  alu_arbiter #(.EXEC_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4),
    .alu_operandA(a4), .alu_operandB(b4), .alu_opcode(op4), .alu_shiftamt(sh4),
    .alu_result(r4), .alu_isNotEqual(ne4), .alu_isLessThan(lt4), .alu_overflow(ov4),
    .busy(busy4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] op, input logic [4:0] sh);
    bus1.req_operandA[idx*32 +: 32] = a;
    bus1.req_operandB[idx*32 +: 32] = b;
    bus1.req_opcode[idx*5 +: 5]     = op;
    bus1.req_shiftamt[idx*5 +: 5]   = sh;
    bus1.req_valid[idx]             = 1'b1;
  endtask

  // One transaction on dut1 with rsp_ready held high; entered just after a negedge in IDLE.
  task automatic run_op(input string tag, input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] op, input logic [4:0] sh,
                        input logic [31:0] er, input logic [2:0] ef);
    int         k;
    logic [1:0] onehot;
    onehot = (idx == 0) ? 2'b01 : 2'b10;
    drive_req(idx, a, b, op, sh);
    #1;
    chk({tag, "_rdy"}, 64'(bus1.req_ready), 64'(onehot));
    @(negedge clk);
    bus1.req_valid = 2'b00;
    #1;
    chk({tag, "_opA"}, 64'(a1), 64'(a));
    chk({tag, "_busy"}, 64'(busy1), 64'(1'b1));
    k = 1;
    while (bus1.rsp_valid == 2'b00 && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk({tag, "_lat"}, 64'(k), 64'(3));
    chk({tag, "_vld"}, 64'(bus1.rsp_valid), 64'(onehot));
    chk({tag, "_res"}, 64'(bus1.rsp_result), 64'(er));
    chk({tag, "_flg"}, 64'(bus1.rsp_flags), 64'(ef));
    chk({tag, "_rdy0"}, 64'(bus1.req_ready), 64'(0));
    @(negedge clk);
    #1;
    chk({tag, "_done"}, 64'(bus1.rsp_valid), 64'(0));
    chk({tag, "_idle"}, 64'(busy1), 64'(0));
  endtask

  logic grants [4];
  logic exp_g  [4];
  int   ng;
  int   k;
  int   pulses;

  initial begin
`ifdef ALU_ARB_RR_EN
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    bus1.req_valid = 2'b11; bus1.req_operandA = '1; bus1.req_operandB = '0;
    bus1.req_opcode = '0;   bus1.req_shiftamt = '0; bus1.rsp_ready = 2'b11;
    bus4.req_valid = 2'b00; bus4.req_operandA = '0; bus4.req_operandB = '0;
    bus4.req_opcode = '0;   bus4.req_shiftamt = '0; bus4.rsp_ready = 2'b11;

    // Reset state, with requests pending to prove ready stays low
    #1 rst_n = 1'b0;
    #1;
    chk("rst_rdy",  64'(bus1.req_ready),  64'(0));
    chk("rst_vld",  64'(bus1.rsp_valid),  64'(0));
    chk("rst_res",  64'(bus1.rsp_result), 64'(0));
    chk("rst_flg",  64'(bus1.rsp_flags),  64'(0));
    chk("rst_opA",  64'(a1),              64'(0));
    chk("rst_busy", 64'(busy1),           64'(0));
    bus1.req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;

    // Directed operations
    run_op("add",   0, 32'd7,          32'd5,          OP_ADD, 5'd0,  32'd12,         3'b100);
    run_op("sub",   1, 32'h7FFF_FFFF,  32'hFFFF_FFFF,  OP_SUB, 5'd0,  32'h8000_0000,  3'b111);
    run_op("and",   0, 32'hF0F0_F0F0,  32'hFF00_FF00,  OP_AND, 5'd0,  32'hF000_F000,  3'b110);
    run_op("sll",   1, 32'd1,          32'd0,          OP_SLL, 5'd31, 32'h8000_0000,  3'b100);
    run_op("sra",   0, 32'h8000_0000,  32'h8000_0000,  OP_SRA, 5'd4,  32'hF800_0000,  3'b000);
    run_op("addov", 1, 32'h7FFF_FFFF,  32'd1,          OP_ADD, 5'd0,  32'h8000_0000,  3'b101);

    // Both requesters held valid: record four grants
    drive_req(0, 32'd1, 32'd2, OP_ADD, 5'd0);
    drive_req(1, 32'd3, 32'd4, OP_ADD, 5'd0);
    ng = 0;
    for (int c = 0; c < 80 && ng < 4; c++) begin
      #1;
      if (bus1.req_ready != 2'b00) begin
        grants[ng] = bus1.req_ready[1];
        ng++;
      end
      @(negedge clk);
    end
    bus1.req_valid = 2'b00;
    chk("arb_count", 64'(ng), 64'(4));
    for (int i = 0; i < 4; i++) chk($sformatf("arb_grant%0d", i), 64'(grants[i]), 64'(exp_g[i]));
    for (int c = 0; c < 6; c++) @(negedge clk);
    #1;
    chk("arb_idle", 64'(busy1), 64'(0));

    // Response back-pressure; requester 0 waits meanwhile, its rsp_ready ignored
    bus1.rsp_ready = 2'b00;
    drive_req(1, 32'd10, 32'd3, OP_SUB, 5'd0);
    #1;
    chk("hold_rdy1", 64'(bus1.req_ready), 64'(2'b10));
    @(negedge clk);
    drive_req(0, 32'd100, 32'd1, OP_ADD, 5'd0);
    bus1.req_valid[1] = 1'b0;
    bus1.rsp_ready = 2'b01;
    #1;
    k = 0;
    while (bus1.rsp_valid == 2'b00 && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("hold_vld%0d", c), 64'(bus1.rsp_valid),  64'(2'b10));
      chk($sformatf("hold_res%0d", c), 64'(bus1.rsp_result), 64'(7));
      chk($sformatf("hold_flg%0d", c), 64'(bus1.rsp_flags),  64'(3'b100));
      chk($sformatf("hold_rdy%0d", c), 64'(bus1.req_ready),  64'(0));
      @(negedge clk);
      #1;
    end
    bus1.rsp_ready = 2'b10;
    @(negedge clk);
    #1;
    chk("hold_done", 64'(bus1.rsp_valid), 64'(0));
    chk("hold_next", 64'(bus1.req_ready), 64'(2'b01));
    bus1.req_valid = 2'b00;
    @(negedge clk);
    #1;
    chk("nohs_busy", 64'(busy1), 64'(0));
    bus1.rsp_ready = 2'b11;

    // EXEC_CYCLES=4 latency
    bus4.req_operandA[31:0] = 32'd2;
    bus4.req_operandB[31:0] = 32'd3;
    bus4.req_opcode[4:0]    = OP_ADD;
    bus4.req_valid          = 2'b01;
    #1;
    chk("e4_rdy", 64'(bus4.req_ready), 64'(2'b01));
    @(negedge clk);
    bus4.req_valid = 2'b00;
    #1;
    k = 1;
    while (bus4.rsp_valid == 2'b00 && k < 30) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("e4_lat", 64'(k), 64'(6));
    chk("e4_res", 64'(bus4.rsp_result), 64'(5));
    @(negedge clk);
    #1;

    // Reset pulsed mid-EXEC abandons the operation
    bus4.req_operandA[31:0] = 32'd9;
    bus4.req_operandB[31:0] = 32'd1;
    bus4.req_opcode[4:0]    = OP_SUB;
    bus4.req_valid          = 2'b01;
    @(negedge clk);
    bus4.req_valid = 2'b00;
    @(negedge clk);
    bus4.req_valid = 2'b01;
    rst_n = 1'b0;
    #1;
    chk("e4rst_vld",  64'(bus4.rsp_valid),  64'(0));
    chk("e4rst_res",  64'(bus4.rsp_result), 64'(0));
    chk("e4rst_flg",  64'(bus4.rsp_flags),  64'(0));
    chk("e4rst_opA",  64'(a4),              64'(0));
    chk("e4rst_opc",  64'(op4),             64'(0));
    chk("e4rst_busy", 64'(busy4),           64'(0));
    chk("e4rst_rdy",  64'(bus4.req_ready),  64'(0));
    bus4.req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #1;
      if (bus4.rsp_valid != 2'b00) pulses++;
    end
    chk("e4rst_norsp", 64'(pulses), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter EXEC_CYCLES, default 1: cycles the ALU operands are held stable before the result is captured; legal range 1..15.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 req_valid  input  2  per-requester operation request; bit i = requester i.
REQ-005 req_ready  output  2  per-requester accept; a request transfers when req_valid[i] & req_ready[i].
REQ-006 req_operandA, req_operandB  input  64 each  packed operands; requester i at [32i+31:32i].
REQ-007 req_opcode, req_shiftamt  input  10 each  packed 5-bit ALU opcode and shift amount; requester i at [5i+4:5i].
REQ-008 alu_operandA, alu_operandB  output  32 each  operands driven to the shared ALU instance.
REQ-009 alu_opcode, alu_shiftamt  output  5 each  control driven to the shared ALU.
REQ-010 alu_result  input  32  ALU data result; alu_isNotEqual, alu_isLessThan, alu_overflow  input  1 each  ALU flags.
REQ-011 rsp_valid  output  2  response available for requester i; at most one bit high.
REQ-012 rsp_ready  input  2  per-requester response accept.
REQ-013 rsp_result  output  32  captured result, meaningful while any rsp_valid bit is high.
REQ-014 rsp_flags  output  3  captured {isNotEqual, isLessThan, overflow}, bit 2 = isNotEqual.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, EXEC, RESP.
REQ-017 In IDLE, req_ready SHALL be high only for the requester selected by the arbiter, and only when that requester's req_valid is high; req_ready is 0 in EXEC and RESP.
REQ-018 On a request handshake, operands, opcode and shiftamt SHALL be registered into the alu_* outputs; the grant index is registered; state goes to EXEC.
REQ-019 alu_* outputs SHALL hold their registered values unchanged from the handshake until the next handshake.
REQ-020 In EXEC, a down-counter loaded with EXEC_CYCLES-1 SHALL decrement each cycle; in the cycle it reads 0, alu_result and the three flags are captured into rsp_result/rsp_flags and state goes to RESP.
REQ-021 Latency: handshake at edge T gives rsp_valid high after edge T+1+EXEC_CYCLES.
REQ-022 In RESP, rsp_valid[grant] SHALL stay high, with rsp_result/rsp_flags stable, until rsp_ready[grant] is high; then state returns to IDLE.
REQ-023 If rsp_ready is already high when rsp_valid rises, the response SHALL complete in that one cycle.
REQ-024 A new grant SHALL NOT occur in the cycle a response completes; earliest next handshake is the following IDLE cycle.
REQ-025 req_valid deasserted without a handshake SHALL have no effect; opcodes are passed through unchecked.
REQ-026 rsp_ready bits for the non-granted requester SHALL be ignored.

Reset
REQ-027 While reset is low: state = IDLE, req_ready = 0, rsp_valid = 0, rsp_result = 0, rsp_flags = 0, alu_* outputs = 0, counter = 0, busy = 0, round-robin pointer = requester 0.
REQ-028 Reset asserted in EXEC or RESP SHALL abandon the operation; no response is ever produced for it.

Configuration
REQ-029 Macro ALU_ARB_RR_EN defined: round-robin arbitration; the requester not granted last has priority, and the pointer updates on every handshake.
REQ-030 ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins simultaneous requests; no pointer register exists.

Structure
REQ-031 Package alu_arb_pkg SHALL hold the state encoding, ALU opcode constants (ADD 00000, SUB 00001, AND 00010, OR 00011, SLL 00100, SRA 00101) and the rsp_flags bit indices.
REQ-032 Arbitration SHALL be a separate sub-module arb2_select (inputs: valid[1:0], pointer; output: one-hot grant).

Verification
REQ-033 Requester 0 sends ADD 7+5, EXEC_CYCLES=1, rsp_ready held high -> rsp_valid[0] for 1 cycle, 2 cycles after the handshake, with rsp_result=12 and rsp_flags=3'b100.
REQ-034 Requester 1 sends SUB 0x7FFFFFFF-0xFFFFFFFF -> rsp_result=0x80000000 and rsp_flags=3'b111.
REQ-035 Both requesters hold valid continuously with ALU_ARB_RR_EN defined -> grants alternate 0,1,0,1; with the macro undefined -> requester 0 is granted every time.
REQ-036 rsp_ready held low for 5 cycles in RESP -> rsp_valid, rsp_result and rsp_flags are stable and req_ready stays 0 throughout.
REQ-037 Reset pulsed low mid-EXEC with EXEC_CYCLES=4 -> all outputs read 0 immediately, and no rsp_valid pulse follows.
